attack_responder: RTL

- Defender-side responder to an attacker's shot request on the 6x6 battleship grid.
- Latches its own player's placed-ship map when placement completes.
- Accepts one attack coordinate at a time over a valid/ready handshake, classifies it as miss, hit, repeat or invalid, and updates its shot and damage maps.
- Returns the result over a second valid/ready handshake and flags fleet destruction. The game FSM and VGA display consume its maps and sunk flag.

---
 rtl/attack_responder_if.sv | 21 ++
 rtl/attack_responder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/attack_responder_if.sv
// Shot request / result handshake between the attacker side and the defending responder.
// The master drives requests and consumes results; the slave is the responder.
interface attack_responder_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_row;
  logic [2:0] req_col;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_code;

  modport master (
    output req_valid, req_row, req_col, rsp_ready,
    input  req_ready, rsp_valid, rsp_code
  );

  modport slave (
    input  req_valid, req_row, req_col, rsp_ready,
    output req_ready, rsp_valid, rsp_code
  );
endinterface

// File: rtl/attack_responder.sv
// Defender-side responder: latches the own ship map, classifies incoming shots,
// keeps shot/damage maps and a registered fleet-destroyed flag.
module attack_responder #(
  parameter int GRID_W = 6,
  parameter int GRID_H = 6,
  parameter int CELLS  = GRID_W * GRID_H
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CELLS-1:0] ships,
  input  logic             ships_lock,
  attack_responder_if.slave bus,
  output logic [CELLS-1:0] shot_map,
  output logic [CELLS-1:0] damage_map,
  output logic [5:0]       shot_count,
  output logic             fleet_sunk
);

  typedef enum logic [1:0] {IDLE, LOOKUP, RESPOND, SUNK} state_t;

  state_t           state_q;
  logic             locked_q;
  logic             decoded_q;
  logic [2:0]       row_q;
  logic [2:0]       col_q;
  logic             inRange_q;
  logic [CELLS-1:0] cellBit_q;
  logic [CELLS-1:0] shipReg_q;
  logic [CELLS-1:0] shotMap_q;
  logic [CELLS-1:0] damageMap_q;
  logic [5:0]       shotCount_q;
  logic             rspValid_q;
  logic [1:0]       rspCode_q;
  logic             fleetSunk_q;

  logic             inRange_d;
  logic [5:0]       idx_d;
  logic [CELLS-1:0] cellBit_d;
  logic [CELLS-1:0] shotMap_d;
  logic [CELLS-1:0] damageMap_d;
  logic [5:0]       shotCount_d;
  logic [1:0]       rspCode_d;
  logic             fleetSunk_d;

  // First LOOKUP cycle registers the decoded cell; the second applies it to the maps.
  always_comb begin
    inRange_d = (row_q < 3'(GRID_H)) && (col_q < 3'(GRID_W));
    idx_d     = {3'b000, row_q} * 6'(GRID_W) + {3'b000, col_q};
    cellBit_d = inRange_d ? ({{(CELLS-1){1'b0}}, 1'b1} << idx_d) : '0;

    shotMap_d   = shotMap_q;
    damageMap_d = damageMap_q;
    shotCount_d = shotCount_q;
    rspCode_d   = rspCode_q;
    if (state_q == LOOKUP && decoded_q) begin
      if (!inRange_q) begin
        rspCode_d = 2'b11;
      end else if ((shotMap_q & cellBit_q) != '0) begin
        rspCode_d = 2'b10;
      end else begin
        shotMap_d   = shotMap_q | cellBit_q;
        shotCount_d = shotCount_q + 6'd1;
        if ((shipReg_q & cellBit_q) != '0) begin
          damageMap_d = damageMap_q | cellBit_q;
          rspCode_d   = 2'b01;
        end else begin
          rspCode_d   = 2'b00;
        end
      end
    end

    // Evaluated on the next damage map so the flag rises together with rsp_valid.
    fleetSunk_d = (shipReg_q != '0) && ((shipReg_q & ~damageMap_d) == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      locked_q    <= 1'b0;
      decoded_q   <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      inRange_q   <= 1'b0;
      cellBit_q   <= '0;
      shipReg_q   <= '0;
      shotMap_q   <= '0;
      damageMap_q <= '0;
      shotCount_q <= '0;
      rspValid_q  <= 1'b0;
      rspCode_q   <= 2'b00;
      fleetSunk_q <= 1'b0;
    end else begin
      shotMap_q   <= shotMap_d;
      damageMap_q <= damageMap_d;
      shotCount_q <= shotCount_d;
      rspCode_q   <= rspCode_d;
      fleetSunk_q <= fleetSunk_d;

      if (!locked_q && ships_lock) begin
        shipReg_q <= ships;
        locked_q  <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (bus.req_valid && locked_q) begin
            row_q     <= bus.req_row;
            col_q     <= bus.req_col;
            decoded_q <= 1'b0;
            state_q   <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (!decoded_q) begin
            cellBit_q <= cellBit_d;
            inRange_q <= inRange_d;
            decoded_q <= 1'b1;
          end else begin
            rspValid_q <= 1'b1;
            state_q    <= RESPOND;
          end
        end
        RESPOND: begin
          if (bus.rsp_ready) begin
            rspValid_q <= 1'b0;
            state_q    <= fleetSunk_q ? SUNK : IDLE;
          end
        end
        SUNK: begin
          state_q <= SUNK;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state_q == IDLE) && locked_q;
  assign bus.rsp_valid = rspValid_q;
  assign bus.rsp_code  = rspCode_q;
  assign shot_map      = shotMap_q;
  assign damage_map    = damageMap_q;
  assign shot_count    = shotCount_q;
  assign fleet_sunk    = fleetSunk_q;

endmodule
